// File: rtl/evm_pkg.sv
// evm_pkg: shared ballot/EVM types, widths and pattern helpers.
package evm_pkg;
   localparam int NUM_CAND = 3;
   localparam int COUNT_W = 32;
   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_DEBOUNCE, S_EMIT, S_LOCKOUT, S_REJECT, S_CLOSED
   } state_t;
   function automatic logic multi_hot(input logic [NUM_CAND-1:0] p);
      return (p & (p - NUM_CAND'(1))) != '0;
   endfunction
endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for the raw candidate buttons.
module btn_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] meta_q, sync_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end
   assign q_o = sync_q;
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: debounced one-vote-per-release ballot controller driving EVM candidate pulses.
module ballot_unit import evm_pkg::*; #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable_vote,
   input  logic               btn1,
   input  logic               btn2,
   input  logic               btn3,
   input  logic               voting_over,
   output logic               cand1,
   output logic               cand2,
   output logic               cand3,
   output logic               ready_led,
   output logic               busy,
   output logic [COUNT_W-1:0] vote_cnt,
   output logic [15:0]        invalid_cnt
);
   localparam logic [7:0] DEB = 8'(DEBOUNCE_CYCLES);
   localparam logic [7:0] LOCK = 8'(LOCKOUT_CYCLES);
   logic [NUM_CAND-1:0] p, pat_q, pat_d;
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [COUNT_W-1:0] vote_cnt_q, vote_cnt_d;
   logic [15:0] invalid_cnt_q, invalid_cnt_d;
   btn_sync #(.W(NUM_CAND)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i ({btn3, btn2, btn1}),
      .q_o (p)
   );
   always_comb begin
      state_d = state_q;
      pat_d = pat_q;
      cnt_d = cnt_q;
      vote_cnt_d = vote_cnt_q;
      case (state_q)
         S_IDLE: state_d = enable_vote ? S_ARMED : S_IDLE;
         S_ARMED: begin
            if (multi_hot(p)) state_d = S_REJECT;
            else if (p != '0) begin
               state_d = S_DEBOUNCE;
               pat_d = p;
               cnt_d = 8'd1;
            end
         end
         // cnt_q counts matching samples already seen, so EMIT follows the DEBOUNCE_CYCLES-th one
         S_DEBOUNCE: begin
            if (multi_hot(p)) state_d = S_REJECT;
            else if (p != pat_q) state_d = S_ARMED;
            else if (cnt_q == DEB) state_d = S_EMIT;
            else cnt_d = cnt_q + 8'd1;
         end
         S_EMIT: begin
            vote_cnt_d = (&vote_cnt_q) ? vote_cnt_q : vote_cnt_q + COUNT_W'(1);
            state_d = voting_over ? S_CLOSED : S_LOCKOUT;
            cnt_d = 8'd1;
         end
         S_LOCKOUT: begin
            if (cnt_q < LOCK) cnt_d = cnt_q + 8'd1;
            else if (p == '0) state_d = S_IDLE;
         end
         S_REJECT: state_d = (p == '0) ? S_ARMED : S_REJECT;
         S_CLOSED: state_d = S_CLOSED;
         default: state_d = S_IDLE;
      endcase
      if (voting_over && state_q != S_EMIT) state_d = S_CLOSED;
      invalid_cnt_d = (state_d == S_REJECT && state_q != S_REJECT && !(&invalid_cnt_q)) ?
                      invalid_cnt_q + 16'd1 : invalid_cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q <= '0;
         cnt_q <= '0;
         vote_cnt_q <= '0;
         invalid_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         pat_q <= pat_d;
         cnt_q <= cnt_d;
         vote_cnt_q <= vote_cnt_d;
         invalid_cnt_q <= invalid_cnt_d;
      end
   end
   assign {cand3, cand2, cand1} = (state_q == S_EMIT) ? pat_q : '0;
   assign ready_led = state_q == S_ARMED;
   assign busy = state_q inside {S_DEBOUNCE, S_EMIT, S_LOCKOUT, S_REJECT};
   assign vote_cnt = vote_cnt_q;
   assign invalid_cnt = invalid_cnt_q;
endmodule

// File: doc/ballot_unit.md
BALLOT_UNIT -- requirements
Module: ballot_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive synchronized cycles a one-hot button pattern must hold before a vote is emitted; legal range 1-255.
REQ-002 Parameter LOCKOUT_CYCLES, default 8: minimum cycles after a vote before the ballot may re-lock; legal range 1-255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable_vote  input  1  presiding-officer release; arms the ballot for one vote.
REQ-006 btn1, btn2, btn3  input  1 each  raw, asynchronous candidate buttons; active-high.
REQ-007 voting_over  input  1  end of poll; synchronous level.
REQ-008 cand1, cand2, cand3  output  1 each  single-cycle vote pulses feeding the EVM counter inputs of the same names.
REQ-009 ready_led  output  1  high only in ARMED.
REQ-010 busy  output  1  high in DEBOUNCE, EMIT, LOCKOUT and REJECT.
REQ-011 vote_cnt  output  32  total votes emitted.
REQ-012 invalid_cnt  output  16  rejected multi-button presses.

Function
REQ-013 Raw buttons SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized 3-bit pattern P.
REQ-014 States SHALL be IDLE, ARMED, DEBOUNCE, EMIT, LOCKOUT, REJECT, CLOSED.
REQ-015 IDLE: enable_vote=1 -> ARMED; buttons ignored; enable_vote in any other state is ignored.
REQ-016 ARMED: P one-hot -> DEBOUNCE with counter=1 and P latched; P with 2+ bits set -> REJECT; P=0 -> stay.
REQ-017 DEBOUNCE: P equal to latched pattern -> counter increments; when counter reaches DEBOUNCE_CYCLES -> EMIT; P changes to 0 or another one-hot pattern -> ARMED; P becomes multi-hot -> REJECT.
REQ-018 EMIT: exactly one of cand1..3, matching the latched pattern, SHALL be high for exactly one cycle; vote_cnt increments by 1; next state LOCKOUT.
REQ-019 Latency: a raw button held stable from edge k SHALL produce its cand pulse in the cycle following edge k+2+DEBOUNCE_CYCLES.
REQ-020 LOCKOUT: counter runs LOCKOUT_CYCLES cycles; exit to IDLE only when counter has expired AND P=0; held buttons SHALL extend LOCKOUT indefinitely.
REQ-021 REJECT: invalid_cnt increments once on entry; stay until P=0, then -> ARMED; no cand pulse is ever produced from REJECT.
REQ-022 At most one cand output SHALL be high in any cycle; no cand output SHALL be high outside EMIT.
REQ-023 voting_over=1 SHALL force CLOSED from every state except EMIT; EMIT completes its pulse and then goes to CLOSED instead of LOCKOUT.
REQ-024 CLOSED is sticky until reset; all cand outputs are 0, and ready_led and busy are 0.
REQ-025 vote_cnt SHALL saturate at 32'hFFFF_FFFF; invalid_cnt SHALL saturate at 16'hFFFF; neither wraps.

Reset
REQ-026 rst=1 SHALL asynchronously set the state to IDLE, clear the synchronizer flops, the latched pattern and both counters, set vote_cnt=0 and invalid_cnt=0, and drive cand1..3, ready_led and busy to 0.
REQ-027 Reset during DEBOUNCE or EMIT SHALL abort the vote; no cand pulse SHALL appear after rst rises.

Structure
REQ-028 Shared package evm_pkg SHALL hold the state encoding, NUM_CAND=3 and COUNT_W=32, which is also the EVM count width.
REQ-029 One sub-module btn_sync SHALL implement the 3-bit two-flop synchronizer with async reset; all other logic stays in ballot_unit.

Verification
REQ-030 Reset, enable_vote pulse, btn1 held 10 cycles -> one cand1 pulse at edge k+6 with defaults; vote_cnt=1; ready_led falls on DEBOUNCE entry.
REQ-031 Armed, btn2 and btn3 pressed together -> no cand pulse; invalid_cnt=1; after release, ready_led=1 again; btn3 alone then yields cand3, vote_cnt=1.
REQ-032 Armed, btn1 glitch of 2 cycles (less than DEBOUNCE_CYCLES) -> no pulse; state returns to ARMED.
REQ-033 After a vote, keep btn2 held 20 cycles and pulse enable_vote -> no second pulse; IDLE reached only after release; enable_vote ignored during LOCKOUT.
REQ-034 voting_over asserted in the same cycle as EMIT -> cand pulse still emitted once, then CLOSED; later enable_vote and buttons give no pulses.
REQ-035 Three voters casting cand1, cand2, cand1 into the EVM -> EVM counts 2/1/0 match vote_cnt=3; rst mid-DEBOUNCE -> no pulse and all outputs 0.
